// File: rtl/evm_pkg.sv
// Shared types and helpers for the multi-candidate voting machine.
package evm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VOTER,
        WAIT_VOTE,
        VOTED,
        TALLY,
        DONE
    } evm_state_e;

    // Candidate id 0 is reserved to mean "no candidate".
    localparam int CAND_NONE = 0;

    function automatic int cand_id_width(input int num_cand);
        return $clog2(num_cand + 1);
    endfunction

endpackage

// File: rtl/evm_tally.sv
// Sequential max/tie scan over the candidate counters, one candidate per cycle.
module evm_tally
    import evm_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int WIDTH    = 8,
    parameter int CW       = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [NUM_CAND-1:0][WIDTH-1:0] i_counts,
    output logic                           o_busy,
    output logic                           o_last,
    output logic [CW-1:0]                  o_max_idx,
    output logic [WIDTH-1:0]               o_max,
    output logic                           o_tie
);

    logic             r_busy;
    logic [CW-1:0]    r_idx;
    logic [CW-1:0]    r_max_idx;
    logic [WIDTH-1:0] r_max;
    logic             r_tie;
    logic [WIDTH-1:0] w_cur;
    logic             w_last;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (r_idx == CW'(i)) begin
                w_cur = i_counts[i];
            end
        end
    end

    assign w_last = r_busy && (r_idx == CW'(NUM_CAND - 1));

    // The running max starts at 0, so an all-zero ballot box ends with the tie flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_idx     <= '0;
            r_max_idx <= '0;
            r_max     <= '0;
            r_tie     <= 1'b0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_max_idx <= '0;
            r_max     <= '0;
            r_tie     <= 1'b0;
        end else if (r_busy) begin
            if (w_cur > r_max) begin
                r_max     <= w_cur;
                r_max_idx <= r_idx;
                r_tie     <= 1'b0;
            end else if (w_cur == r_max) begin
                r_tie <= 1'b1;
            end
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_idx <= r_idx + CW'(1);
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_last    = w_last;
    assign o_max_idx = r_max_idx;
    assign o_max     = r_max;
    assign o_tie     = r_tie;

endmodule

// File: rtl/evm_multi.sv
// Parametrised voting machine controller; define EVM_VOTER_TIMEOUT_EN to enable
// the voter idle timeout in the vote-wait state.
module evm_multi
    import evm_pkg::*;
#(
    parameter  int NUM_CAND       = 4,
    parameter  int WIDTH          = 8,
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int CW             = cand_id_width(NUM_CAND)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                switch_on_evm,
    input  logic                candidate_ready,
    input  logic [NUM_CAND-1:0] vote_btn,
    input  logic                voting_session_done,
    input  logic [CW-1:0]       display_sel,
    input  logic                display_winner,
    output logic [CW-1:0]       candidate_id,
    output logic [WIDTH-1:0]    results,
    output logic                invalid_results,
    output logic                voting_in_progress,
    output logic                voting_done,
    output logic                tally_busy,
    output logic                vote_timeout
);

    evm_state_e                     r_state;
    evm_state_e                     w_next;
    logic [NUM_CAND-1:0][WIDTH-1:0] r_count;
    logic [NUM_CAND-1:0]            r_vote_oh;
    logic                           w_vote_ok;
    logic                           w_clear;
    logic                           w_start_scan;
    logic                           w_timeout_hit;
    logic                           w_scan_busy;
    logic                           w_scan_last;
    logic [CW-1:0]                  w_max_idx;
    logic [WIDTH-1:0]               w_max;
    logic                           w_tie;

    assign w_vote_ok    = (r_state == WAIT_VOTE) && !candidate_ready && $onehot(vote_btn);
    assign w_clear      = (r_state == IDLE) && switch_on_evm;
    assign w_start_scan = (r_state == WAIT_VOTER) && (w_next == TALLY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next             = r_state;
        candidate_id       = CW'(CAND_NONE);
        results            = '0;
        invalid_results    = 1'b0;
        voting_in_progress = 1'b0;
        voting_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (switch_on_evm) w_next = WAIT_VOTER;
            end
            WAIT_VOTER: begin
                if (candidate_ready) w_next = WAIT_VOTE;
                else if (voting_session_done) w_next = TALLY;
            end
            WAIT_VOTE: begin
                voting_in_progress = 1'b1;
                if (w_vote_ok) w_next = VOTED;
                else if (w_timeout_hit) w_next = WAIT_VOTER;
            end
            VOTED: begin
                voting_done = 1'b1;
                w_next      = candidate_ready ? WAIT_VOTE : WAIT_VOTER;
            end
            TALLY: begin
                if (w_scan_last) w_next = DONE;
            end
            DONE: begin
                invalid_results = w_tie;
                if (display_winner) begin
                    if (!w_tie) begin
                        candidate_id = w_max_idx + CW'(1);
                        results      = w_max;
                    end
                end else begin
                    for (int i = 0; i < NUM_CAND; i++) begin
                        if (display_sel == CW'(i)) begin
                            candidate_id = CW'(i + 1);
                            results      = r_count[i];
                        end
                    end
                end
                if (!switch_on_evm) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The button is latched one-hot so VOTED can bump exactly one saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_vote_oh <= '0;
        end else begin
            if (w_vote_ok) begin
                r_vote_oh <= vote_btn;
            end
            for (int i = 0; i < NUM_CAND; i++) begin
                if (w_clear) begin
                    r_count[i] <= '0;
                end else if ((r_state == VOTED) && r_vote_oh[i] && (r_count[i] != '1)) begin
                    r_count[i] <= r_count[i] + WIDTH'(1);
                end
            end
        end
    end

    evm_tally #(
        .NUM_CAND (NUM_CAND),
        .WIDTH    (WIDTH),
        .CW       (CW)
    ) u_tally (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start_scan),
        .i_counts  (r_count),
        .o_busy    (w_scan_busy),
        .o_last    (w_scan_last),
        .o_max_idx (w_max_idx),
        .o_max     (w_max),
        .o_tie     (w_tie)
    );

    assign tally_busy = w_scan_busy;

`ifdef EVM_VOTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_to_pulse;

    assign w_timeout_hit = (r_state == WAIT_VOTE) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero outside WAIT_VOTE, so every entry starts a fresh window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt   <= '0;
            r_to_pulse <= 1'b0;
        end else begin
            r_to_pulse <= w_timeout_hit && !w_vote_ok;
            if (r_state == WAIT_VOTE) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign vote_timeout = r_to_pulse;
`else
    assign w_timeout_hit = 1'b0;
    assign vote_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_evm_multi.sv
// Scoreboard bench for evm_multi (NUM_CAND=4, WIDTH=8, TIMEOUT_CYCLES=10).
module tb_evm_multi;

    localparam int NC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       switch_on_evm = 1'b0;
    logic       candidate_ready = 1'b0;
    logic [3:0] vote_btn = '0;
    logic       voting_session_done = 1'b0;
    logic [2:0] display_sel = '0;
    logic       display_winner = 1'b0;
    logic [2:0] candidate_id;
    logic [7:0] results;
    logic       invalid_results;
    logic       voting_in_progress;
    logic       voting_done;
    logic       tally_busy;
    logic       vote_timeout;

    typedef struct {
        string      tag;
        logic [2:0] id;
        logic [7:0] res;
        logic       inv;
    } exp_t;

    exp_t sbq[$];
    int   mCount[NC];
    int   total = 0;
    int   bad = 0;

    evm_multi #(
        .NUM_CAND       (4),
        .WIDTH          (8),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .switch_on_evm       (switch_on_evm),
        .candidate_ready     (candidate_ready),
        .vote_btn            (vote_btn),
        .voting_session_done (voting_session_done),
        .display_sel         (display_sel),
        .display_winner      (display_winner),
        .candidate_id        (candidate_id),
        .results             (results),
        .invalid_results     (invalid_results),
        .voting_in_progress  (voting_in_progress),
        .voting_done         (voting_done),
        .tally_busy          (tally_busy),
        .vote_timeout        (vote_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: probe < 0 asks for the winner view, otherwise a 0-based index.
    function automatic exp_t predict(string tag, int probe);
        exp_t e;
        int   mx = 0;
        int   occ = 0;
        int   first = -1;
        for (int i = 0; i < NC; i++) if (mCount[i] > mx) mx = mCount[i];
        for (int i = 0; i < NC; i++) begin
            if (mCount[i] == mx) begin
                occ++;
                if (first < 0) first = i;
            end
        end
        e.tag = tag;
        e.inv = (occ > 1);
        e.id  = '0;
        e.res = '0;
        if (probe < 0) begin
            if (occ == 1) begin
                e.id  = 3'(first + 1);
                e.res = 8'(mx);
            end
        end else if (probe < NC) begin
            e.id  = 3'(probe + 1);
            e.res = 8'(mCount[probe]);
        end
        return e;
    endfunction

    task automatic start_session();
        switch_on_evm = 1'b1;
        tick();
        for (int i = 0; i < NC; i++) mCount[i] = 0;
    endtask

    task automatic cast_vote(input int id);
        candidate_ready = 1'b1;
        tick();
        candidate_ready = 1'b0;
        vote_btn = 4'(1 << (id - 1));
        tick();
        vote_btn = '0;
        tick();
        if (mCount[id - 1] < 255) mCount[id - 1]++;
    endtask

    task automatic close_session(output int busyCycles);
        voting_session_done = 1'b1;
        tick();
        voting_session_done = 1'b0;
        busyCycles = 0;
        while (tally_busy && busyCycles < 20) begin
            busyCycles++;
            tick();
        end
    endtask

    task automatic end_session();
        switch_on_evm = 1'b0;
        display_winner = 1'b0;
        display_sel = '0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({candidate_id, results, invalid_results, voting_in_progress, voting_done, tally_busy, vote_timeout} !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset_hold: got %h want 0", {candidate_id, results, invalid_results, voting_in_progress, voting_done, tally_busy, vote_timeout});
        end
        rst = 1'b0;
        tick();
        total++;
        if ({candidate_id, results, invalid_results, voting_in_progress, voting_done, tally_busy, vote_timeout} !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset_release: got %h want 0", {candidate_id, results, invalid_results, voting_in_progress, voting_done, tally_busy, vote_timeout});
        end
    endtask

    task automatic test_majority();
        int   ids[5] = '{1, 2, 2, 3, 2};
        int   probes[7] = '{-1, 0, 1, 2, 3, 4, 5};
        int   busyCycles;
        exp_t e;
        start_session();
        candidate_ready = 1'b1;
        tick();
        total++;
        if (voting_in_progress !== 1'b1) begin
            bad++;
            $display("[TB] FAIL maj_vip: got %b want 1", voting_in_progress);
        end
        candidate_ready = 1'b0;
        vote_btn = 4'b0001;
        tick();
        vote_btn = '0;
        total++;
        if ({voting_in_progress, voting_done} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL maj_voted: got %b want 01", {voting_in_progress, voting_done});
        end
        tick();
        total++;
        if (voting_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL maj_voted_once: got %b want 0", voting_done);
        end
        mCount[0]++;
        for (int k = 1; k < 5; k++) cast_vote(ids[k]);
        close_session(busyCycles);
        total++;
        if (busyCycles != NC) begin
            bad++;
            $display("[TB] FAIL maj_busy_len: got %0d want %0d", busyCycles, NC);
        end
        foreach (probes[k]) begin
            display_winner = (probes[k] < 0);
            display_sel = (probes[k] < 0) ? 3'd1 : 3'(probes[k]);
            sbq.push_back(predict($sformatf("maj_p%0d", probes[k]), probes[k]));
            #1;
            e = sbq.pop_front();
            total++;
            if ({candidate_id, results, invalid_results} !== {e.id, e.res, e.inv}) begin
                bad++;
                $display("[TB] FAIL %s: got id=%0d res=%0d inv=%b want id=%0d res=%0d inv=%b", e.tag, candidate_id, results, invalid_results, e.id, e.res, e.inv);
            end
        end
        end_session();
        total++;
        if ({candidate_id, results, invalid_results} !== 12'h0) begin
            bad++;
            $display("[TB] FAIL maj_idle: got id=%0d res=%0d want 0/0", candidate_id, results);
        end
    endtask

    task automatic test_tie();
        int   probes[3] = '{-1, 2, 0};
        int   busyCycles;
        exp_t e;
        start_session();
        cast_vote(1);
        cast_vote(3);
        close_session(busyCycles);
        foreach (probes[k]) begin
            display_winner = (probes[k] < 0);
            display_sel = (probes[k] < 0) ? 3'd2 : 3'(probes[k]);
            sbq.push_back(predict($sformatf("tie_p%0d", probes[k]), probes[k]));
            #1;
            e = sbq.pop_front();
            total++;
            if ({candidate_id, results, invalid_results} !== {e.id, e.res, e.inv}) begin
                bad++;
                $display("[TB] FAIL %s: got id=%0d res=%0d inv=%b want id=%0d res=%0d inv=%b", e.tag, candidate_id, results, invalid_results, e.id, e.res, e.inv);
            end
        end
        end_session();
    endtask

    task automatic test_onehot();
        logic [3:0] bads[4] = '{4'b0110, 4'b0110, 4'b1111, 4'b0000};
        int         probes[3] = '{2, 1, -1};
        int         busyCycles;
        exp_t       e;
        start_session();
        candidate_ready = 1'b1;
        tick();
        candidate_ready = 1'b0;
        foreach (bads[k]) begin
            vote_btn = bads[k];
            tick();
            total++;
            if ({voting_in_progress, voting_done} !== 2'b10) begin
                bad++;
                $display("[TB] FAIL onehot_reject_%0d: got %b want 10", k, {voting_in_progress, voting_done});
            end
        end
        vote_btn = 4'b0100;
        tick();
        vote_btn = '0;
        total++;
        if (voting_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL onehot_accept: got %b want 1", voting_done);
        end
        tick();
        mCount[2]++;
        close_session(busyCycles);
        foreach (probes[k]) begin
            display_winner = (probes[k] < 0);
            display_sel = (probes[k] < 0) ? 3'd0 : 3'(probes[k]);
            sbq.push_back(predict($sformatf("onehot_p%0d", probes[k]), probes[k]));
            #1;
            e = sbq.pop_front();
            total++;
            if ({candidate_id, results, invalid_results} !== {e.id, e.res, e.inv}) begin
                bad++;
                $display("[TB] FAIL %s: got id=%0d res=%0d inv=%b want id=%0d res=%0d inv=%b", e.tag, candidate_id, results, invalid_results, e.id, e.res, e.inv);
            end
        end
        end_session();
    endtask

    task automatic test_saturation();
        int   probes[3] = '{3, -1, 0};
        int   busyCycles;
        exp_t e;
        start_session();
        for (int n = 0; n < 300; n++) cast_vote(4);
        close_session(busyCycles);
        foreach (probes[k]) begin
            display_winner = (probes[k] < 0);
            display_sel = (probes[k] < 0) ? 3'd0 : 3'(probes[k]);
            sbq.push_back(predict($sformatf("sat_p%0d", probes[k]), probes[k]));
            #1;
            e = sbq.pop_front();
            total++;
            if ({candidate_id, results, invalid_results} !== {e.id, e.res, e.inv}) begin
                bad++;
                $display("[TB] FAIL %s: got id=%0d res=%0d inv=%b want id=%0d res=%0d inv=%b", e.tag, candidate_id, results, invalid_results, e.id, e.res, e.inv);
            end
        end
        end_session();
    endtask

    task automatic test_reset_in_tally();
        int   probes[2] = '{-1, 1};
        int   busyCycles;
        exp_t e;
        start_session();
        cast_vote(2);
        voting_session_done = 1'b1;
        tick();
        voting_session_done = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({candidate_id, results, invalid_results, voting_in_progress, voting_done, tally_busy, vote_timeout} !== 16'h0) begin
            bad++;
            $display("[TB] FAIL rst_tally_outs: got %h want 0", {candidate_id, results, invalid_results, voting_in_progress, voting_done, tally_busy, vote_timeout});
        end
        switch_on_evm = 1'b0;
        for (int i = 0; i < NC; i++) mCount[i] = 0;
        #2;
        rst = 1'b0;
        candidate_ready = 1'b1;
        tick();
        tick();
        candidate_ready = 1'b0;
        total++;
        if ({voting_in_progress, tally_busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL rst_tally_idle: got %b want 00", {voting_in_progress, tally_busy});
        end
        start_session();
        close_session(busyCycles);
        foreach (probes[k]) begin
            display_winner = (probes[k] < 0);
            display_sel = (probes[k] < 0) ? 3'd0 : 3'(probes[k]);
            sbq.push_back(predict($sformatf("rst_p%0d", probes[k]), probes[k]));
            #1;
            e = sbq.pop_front();
            total++;
            if ({candidate_id, results, invalid_results} !== {e.id, e.res, e.inv}) begin
                bad++;
                $display("[TB] FAIL %s: got id=%0d res=%0d inv=%b want id=%0d res=%0d inv=%b", e.tag, candidate_id, results, invalid_results, e.id, e.res, e.inv);
            end
        end
        end_session();
    endtask

    task automatic test_back_to_back();
        int   probes[3] = '{-1, 1, 0};
        int   busyCycles;
        exp_t e;
        start_session();
        switch_on_evm = 1'b0;
        candidate_ready = 1'b1;
        voting_session_done = 1'b1;
        tick();
        voting_session_done = 1'b0;
        total++;
        if ({voting_in_progress, tally_busy} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL b2b_ready_wins: got %b want 10", {voting_in_progress, tally_busy});
        end
        vote_btn = 4'b0001;
        tick();
        total++;
        if (voting_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_ready_blocks: got %b want 0", voting_done);
        end
        candidate_ready = 1'b0;
        tick();
        vote_btn = '0;
        candidate_ready = 1'b1;
        mCount[0]++;
        total++;
        if (voting_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_first: got %b want 1", voting_done);
        end
        tick();
        candidate_ready = 1'b0;
        total++;
        if ({voting_in_progress, voting_done} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL b2b_reenter: got %b want 10", {voting_in_progress, voting_done});
        end
        vote_btn = 4'b0010;
        tick();
        vote_btn = '0;
        mCount[1]++;
        tick();
        total++;
        if ({voting_in_progress, voting_done} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL b2b_wait_voter: got %b want 00", {voting_in_progress, voting_done});
        end
        switch_on_evm = 1'b1;
        close_session(busyCycles);
        foreach (probes[k]) begin
            display_winner = (probes[k] < 0);
            display_sel = (probes[k] < 0) ? 3'd1 : 3'(probes[k]);
            sbq.push_back(predict($sformatf("b2b_p%0d", probes[k]), probes[k]));
            #1;
            e = sbq.pop_front();
            total++;
            if ({candidate_id, results, invalid_results} !== {e.id, e.res, e.inv}) begin
                bad++;
                $display("[TB] FAIL %s: got id=%0d res=%0d inv=%b want id=%0d res=%0d inv=%b", e.tag, candidate_id, results, invalid_results, e.id, e.res, e.inv);
            end
        end
        end_session();
    endtask

    task automatic test_timeout();
        int   probes[3] = '{0, 1, -1};
        int   busyCycles;
        int   seenAt = 0;
        exp_t e;
        start_session();
        cast_vote(1);
        candidate_ready = 1'b1;
        tick();
        candidate_ready = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (vote_timeout === 1'b1) begin
                seenAt = n;
                break;
            end
        end
`ifdef EVM_VOTER_TIMEOUT_EN
        total++;
        if (seenAt != 10) begin
            bad++;
            $display("[TB] FAIL to_cycle: got %0d want 10", seenAt);
        end
        total++;
        if (voting_in_progress !== 1'b0) begin
            bad++;
            $display("[TB] FAIL to_state: got vip=%b want 0", voting_in_progress);
        end
        tick();
        total++;
        if (vote_timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL to_pulse_len: got %b want 0", vote_timeout);
        end
`else
        total++;
        if (seenAt != 0) begin
            bad++;
            $display("[TB] FAIL to_disabled: got pulse at %0d want none", seenAt);
        end
        total++;
        if (voting_in_progress !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_wait_forever: got vip=%b want 1", voting_in_progress);
        end
        vote_btn = 4'b0001;
        tick();
        vote_btn = '0;
        tick();
        mCount[0]++;
`endif
        close_session(busyCycles);
        foreach (probes[k]) begin
            display_winner = (probes[k] < 0);
            display_sel = (probes[k] < 0) ? 3'd3 : 3'(probes[k]);
            sbq.push_back(predict($sformatf("to_p%0d", probes[k]), probes[k]));
            #1;
            e = sbq.pop_front();
            total++;
            if ({candidate_id, results, invalid_results} !== {e.id, e.res, e.inv}) begin
                bad++;
                $display("[TB] FAIL %s: got id=%0d res=%0d inv=%b want id=%0d res=%0d inv=%b", e.tag, candidate_id, results, invalid_results, e.id, e.res, e.inv);
            end
        end
        end_session();
    endtask

    initial begin
        $display("[TB] evm_multi bench start");
        test_reset();
        test_majority();
        test_tie();
        test_onehot();
        test_saturation();
        test_reset_in_tally();
        test_back_to_back();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
